// File: rtl/counter_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sched_pkg
//  Brief    : Shared FSM state encodings and helpers for counter_sched.
//  Revision : 1.0  initial release
// ============================================================================
package counter_sched_pkg;

    // FSM state encodings; 2'd3 is illegal and steers back to IDLE
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Widest one-hot vector the index helper accepts
    localparam int MAX_REQ = 32;

    // Position of the set bit in a one-hot vector (0 when the vector is empty)
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage : counter_sched_pkg
`default_nettype wire

// File: rtl/counter_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin picker. Searches last+1, last+2, ...
//             modulo NREQ and returns the first requester found, both as a
//             one-hot vector and as an index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    logic [MAX_REQ-1:0] w_grant_ext;

    // Rotating priority search starting just after the previous winner
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!valid_o && req_i[(int'(last_i) + k) % NREQ]) begin
                grant_o[(int'(last_i) + k) % NREQ] = 1'b1;
                valid_o = 1'b1;
            end
        end
    end

    // Widen the one-hot winner so the shared helper can encode it
    always_comb begin
        w_grant_ext              = '0;
        w_grant_ext[NREQ-1:0]    = grant_o;
        idx_o                    = IDXW'(onehot_to_idx(w_grant_ext));
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sched
//  Brief    : Time-shares one N-bit up-counter among NREQ requesters. A
//             round-robin arbiter picks an owner, the counter runs for the
//             owner's latched interval, then a one-cycle done pulse is sent.
//  Revision : 1.0  initial release
// ============================================================================
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*N-1:0] len_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic [N-1:0]      count_o,
    output logic [NREQ-1:0]   done_o
);

    localparam int IDXW = $clog2(NREQ);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q,  busy_d;
    logic [N-1:0]    count_q, count_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic [N-1:0]    lenq_q,  lenq_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] last_q,  last_d;

    logic [N-1:0]    w_len [NREQ];
    logic [NREQ-1:0] w_arb_grant;
    logic [IDXW-1:0] w_arb_idx;
    logic            w_arb_valid;

    // Unpack the flat length bus into one slice per requester
    for (genvar i = 0; i < NREQ; i++) begin : g_len
        assign w_len[i] = len_i[i*N +: N];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req_i   (req_i),
        .last_i  (last_q),
        .grant_o (w_arb_grant),
        .idx_o   (w_arb_idx),
        .valid_o (w_arb_valid)
    );

    // Next-state logic: arbitrate in IDLE, count in RUN, one-cycle DONE
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        count_d = count_q;
        done_d  = '0;
        lenq_d  = lenq_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                if (w_arb_valid) begin
                    state_d = RUN;
                    grant_d = w_arb_grant;
                    busy_d  = 1'b1;
                    // A zero length still runs for one count
                    lenq_d  = (w_len[w_arb_idx] == '0) ? N'(1) : w_len[w_arb_idx];
                    owner_d = w_arb_idx;
                    last_d  = w_arb_idx;
                end
            end
            RUN: begin
                if (!req_i[owner_q]) begin
                    // Owner withdrew: release silently, no done pulse
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else if (count_q == lenq_q - N'(1)) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else begin
                    count_d = count_q + N'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State registers; reset abandons any interval in progress without done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            done_q  <= '0;
            lenq_q  <= '0;
            owner_q <= '0;
            last_q  <= IDXW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            done_q  <= done_d;
            lenq_q  <= lenq_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;
    assign count_o = count_q;
    assign done_o  = done_q;

endmodule : counter_sched
`default_nettype wire

// File: tb/tb_counter_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_sched
//  Brief    : Directed self-checking bench for counter_sched.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_sched;

    localparam int NREQ = 4;
    localparam int N    = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] len;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [N-1:0]      count;
    logic [NREQ-1:0]   done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_done_cyc;

    counter_sched #(
        .NREQ (NREQ),
        .N    (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .len_i   (len),
        .grant_o (grant),
        .busy_o  (busy),
        .count_o (count),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter for spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Advance one clock; inputs change and outputs are sampled 2 units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_len(input int idx, input logic [N-1:0] v);
        len[idx*N +: N] = v;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        len = '0;
        do_reset();

        // Reset state
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_done",  32'(done),  32'h0);

        // 1: single request, len=5
        set_len(0, 8'd5);
        req = 4'b0001;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy",  32'(busy),  32'h1);
        chk("t1_cnt0",  32'(count), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_cnt", 32'(count), 32'(k));
        end
        tick();
        chk("t1_done",   32'(done),  32'h1);
        chk("t1_busy0",  32'(busy),  32'h0);
        chk("t1_grant0", 32'(grant), 32'h0);
        req = '0;
        tick();
        chk("t1_done_clr", 32'(done),  32'h0);
        tick();
        chk("t1_idle",     32'(grant), 32'h0);

        // 2: zero length treated as one
        set_len(2, 8'd0);
        req = 4'b0100;
        tick();
        chk("t2_grant", 32'(grant), 32'h4);
        chk("t2_cnt0",  32'(count), 32'h0);
        tick();
        chk("t2_done",  32'(done),  32'h4);
        chk("t2_cnt",   32'(count), 32'h0);
        req = '0;
        tick();
        chk("t2_done_clr", 32'(done), 32'h0);

        // 3: all requesting, round-robin order and done spacing
        do_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 8'd3);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_grant", 32'(grant), 32'(1 << (i % NREQ)));
            tick();
            tick();
            chk("t3_cnt2", 32'(count), 32'h2);
            tick();
            chk("t3_done", 32'(done), 32'(1 << (i % NREQ)));
            if (i > 0) chk("t3_spacing", 32'(cyc - last_done_cyc), 32'd5);
            last_done_cyc = cyc;
            tick();
            chk("t3_idle", 32'(grant), 32'h0);
        end
        req = '0;

        // 4: owner cancels mid-interval, pending requester takes over
        do_reset();
        set_len(1, 8'd8);
        set_len(3, 8'd2);
        req = 4'b1010;
        tick();
        chk("t4_grant1", 32'(grant), 32'h2);
        tick();
        tick();
        chk("t4_cnt2", 32'(count), 32'h2);
        req = 4'b1000;
        tick();
        chk("t4_cancel_grant", 32'(grant), 32'h0);
        chk("t4_cancel_busy",  32'(busy),  32'h0);
        chk("t4_cancel_done",  32'(done),  32'h0);
        tick();
        chk("t4_grant3", 32'(grant), 32'h8);
        chk("t4_cnt0",   32'(count), 32'h0);
        req = '0;
        tick();
        chk("t4_cancel2_grant", 32'(grant), 32'h0);
        chk("t4_cancel2_done",  32'(done),  32'h0);

        // 5: reset in the middle of an interval
        do_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 8'd10);
        req = 4'b0001;
        tick();
        for (int k = 1; k <= 4; k++) tick();
        chk("t5_cnt4", 32'(count), 32'h4);
        rst = 1'b1;
        req = 4'b1111;
        tick();
        chk("t5_rst_grant", 32'(grant), 32'h0);
        chk("t5_rst_count", 32'(count), 32'h0);
        chk("t5_rst_done",  32'(done),  32'h0);
        chk("t5_rst_busy",  32'(busy),  32'h0);
        rst = 1'b0;
        tick();
        chk("t5_grant0", 32'(grant), 32'h1);
        chk("t5_done0",  32'(done),  32'h0);
        req = '0;

        // 6: length change during RUN is ignored
        do_reset();
        set_len(2, 8'd3);
        req = 4'b0100;
        tick();
        chk("t6_grant", 32'(grant), 32'h4);
        set_len(2, 8'd9);
        tick();
        chk("t6_cnt1", 32'(count), 32'h1);
        tick();
        chk("t6_cnt2", 32'(count), 32'h2);
        tick();
        chk("t6_done", 32'(done),  32'h4);
        chk("t6_busy", 32'(busy),  32'h0);
        req = '0;
        tick();
        chk("t6_done_clr", 32'(done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_counter_sched
`default_nettype wire
